data_memory_bank: RTL

- Parametrised byte-addressed data memory for the MEM stage of the MIPS-lite pipeline; successor to the fixed-width word-only data memory.
- Adds byte/halfword/word access with sign/zero extension, a configurable registered read latency and a valid/ready request interface.
- Adds alignment and range error reporting, and a hardware clear sequencer that runs after reset.

---
 rtl/data_memory_bank.sv | 265 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/data_memory_bank.sv
// ---------------------------------------------------------------------------
// data_memory_bank
//
// Byte-addressed data memory for the MEM stage of the MIPS-lite pipeline.
// Supports byte / halfword / word loads and stores (big-endian lane order),
// sign or zero extension on loads, a registered response pipeline of
// READ_LATENCY cycles, alignment and range error reporting, and a clear
// sequencer that writes INIT_VALUE to every word after reset.
//
// Optional feature macro: DMEM_WRITE_TRACK_EN
//   When defined, a per-word "written" bit is kept and the rsp_uninit port
//   flags loads that touch a word never stored since the last clear.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous, active-high reset
//   req_valid   request present
//   req_ready   block can accept a request (high once the clear is done)
//   req_write   1 = store, 0 = load
//   req_size    00 byte, 01 half, 10 word, 11 illegal
//   req_signed  loads sign-extend when 1, zero-extend when 0
//   req_addr    byte address
//   req_wdata   store data, right-justified
//   rsp_valid   one-cycle response pulse, READ_LATENCY cycles after accept
//   rsp_rdata   load result; 0 for stores and errors
//   rsp_err     request was misaligned, out of range or illegal size
//   rsp_uninit  (DMEM_WRITE_TRACK_EN only) load touched an unwritten word
//   init_busy   clear sequencer is running
// ---------------------------------------------------------------------------
module data_memory_bank #(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    DEPTH_BYTES  = 4096,
  parameter int                    READ_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = 32'h0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
`ifdef DMEM_WRITE_TRACK_EN
  output logic                  rsp_uninit,
`endif
  output logic                  init_busy
);

  localparam int DEPTH_WORDS = DEPTH_BYTES / 4;
  localparam int PTR_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;

  logic [DATA_WIDTH-1:0]  mem_q [DEPTH_WORDS];

  // Response pipeline: index 0 is loaded on the accepting edge, the last
  // index drives the response ports.
  logic [READ_LATENCY-1:0]                 pv_q, pv_d;
  logic [READ_LATENCY-1:0]                 pe_q, pe_d;
  logic [READ_LATENCY-1:0][DATA_WIDTH-1:0] pd_q, pd_d;

  logic                  accept;
  logic [1:0]            off;
  logic [PTR_W-1:0]      widx;
  logic [2:0]            nbytes;
  logic [ADDR_WIDTH:0]   end_addr;
  logic                  req_err;
  logic [DATA_WIDTH-1:0] rword;
  logic [7:0]            lb;
  logic [15:0]           lh;
  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] st_data;
  logic [DATA_WIDTH-1:0] st_mask;
  logic                  store_ok;

  logic                  mem_we;
  logic [PTR_W-1:0]      mem_widx;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_wmask;

  assign req_ready = (state_q == S_READY);
  assign init_busy = (state_q == S_CLEAR);
  assign accept    = req_valid && req_ready;

  // Request decode: error classification, big-endian lane extraction for
  // loads and lane mask/data replication for stores.
  always_comb begin
    off      = req_addr[1:0];
    widx     = req_addr[PTR_W+1:2];
    nbytes   = 3'd4;
    lb       = '0;
    lh       = '0;
    load_data = '0;
    st_data  = req_wdata;
    st_mask  = '1;

    case (req_size)
      2'b00:   nbytes = 3'd1;
      2'b01:   nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase

    // Range check is done one bit wider so addresses near the top of the
    // address space cannot wrap back into range.
    end_addr = {1'b0, req_addr} + {{(ADDR_WIDTH-2){1'b0}}, nbytes};
    req_err  = (req_size == 2'b11)
            || ((req_size == 2'b01) && off[0])
            || ((req_size == 2'b10) && (off != 2'b00))
            || (end_addr > (ADDR_WIDTH+1)'(DEPTH_BYTES));

    rword = mem_q[widx];

    case (req_size)
      2'b00: begin
        case (off)
          2'd0:    lb = rword[31:24];
          2'd1:    lb = rword[23:16];
          2'd2:    lb = rword[15:8];
          default: lb = rword[7:0];
        endcase
        load_data = {{24{req_signed & lb[7]}}, lb};
        st_data   = {4{req_wdata[7:0]}};
        st_mask   = 32'hFF00_0000 >> {off, 3'b000};
      end
      2'b01: begin
        lh        = off[1] ? rword[15:0] : rword[31:16];
        load_data = {{16{req_signed & lh[15]}}, lh};
        st_data   = {2{req_wdata[15:0]}};
        st_mask   = off[1] ? 32'h0000_FFFF : 32'hFFFF_0000;
      end
      default: begin
        load_data = rword;
        st_data   = req_wdata;
        st_mask   = '1;
      end
    endcase

    store_ok = accept && req_write && !req_err;
  end

  // Clear sequencer: one word per cycle from word 0 up to the last word,
  // then READY until the next reset.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      S_CLEAR: begin
        ptr_d = ptr_q + PTR_W'(1);
        if (ptr_q == PTR_W'(DEPTH_WORDS - 1)) begin
          state_d = S_READY;
          ptr_d   = '0;
        end
      end
      default: state_d = S_READY;
    endcase
  end

  // Single write port shared by the clear sequencer and stores; stores can
  // only arrive once the clear is finished, so there is no conflict.
  always_comb begin
    mem_we    = 1'b0;
    mem_widx  = widx;
    mem_wdata = st_data;
    mem_wmask = st_mask;
    if (state_q == S_CLEAR) begin
      mem_we    = 1'b1;
      mem_widx  = ptr_q;
      mem_wdata = INIT_VALUE;
      mem_wmask = '1;
    end else if (store_ok) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_widx] <= (mem_q[mem_widx] & ~mem_wmask) | (mem_wdata & mem_wmask);
    end
  end

  // Response pipeline shift. Data slots carry 0 unless a clean load was
  // accepted, so stores and errors respond with rdata = 0.
  always_comb begin
    pv_d    = '0;
    pe_d    = '0;
    pd_d    = '0;
    pv_d[0] = accept;
    pe_d[0] = accept && req_err;
    pd_d[0] = (accept && !req_write && !req_err) ? load_data : '0;
    for (int i = 1; i < READ_LATENCY; i++) begin
      pv_d[i] = pv_q[i-1];
      pe_d[i] = pe_q[i-1];
      pd_d[i] = pd_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_CLEAR;
      ptr_q   <= '0;
      pv_q    <= '0;
      pe_q    <= '0;
      pd_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      pv_q    <= pv_d;
      pe_q    <= pe_d;
      pd_q    <= pd_d;
    end
  end

  assign rsp_valid = pv_q[READ_LATENCY-1];
  assign rsp_err   = pe_q[READ_LATENCY-1];
  assign rsp_rdata = pd_q[READ_LATENCY-1];

`ifdef DMEM_WRITE_TRACK_EN
  logic [DEPTH_WORDS-1:0]  written_q, written_d;
  logic [READ_LATENCY-1:0] pu_q, pu_d;

  // Written bits are cleared word by word alongside the memory and set by
  // any clean store; aligned accesses never straddle two words.
  always_comb begin
    written_d = written_q;
    if (state_q == S_CLEAR) begin
      written_d[ptr_q] = 1'b0;
    end else if (store_ok) begin
      written_d[widx] = 1'b1;
    end
  end

  always_comb begin
    pu_d    = '0;
    pu_d[0] = accept && !req_write && !req_err && !written_q[widx];
    for (int i = 1; i < READ_LATENCY; i++) begin
      pu_d[i] = pu_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      written_q <= '0;
      pu_q      <= '0;
    end else begin
      written_q <= written_d;
      pu_q      <= pu_d;
    end
  end

  assign rsp_uninit = pu_q[READ_LATENCY-1];
`endif

endmodule
